// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmitter
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO between the CPU handshake and the serializer
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - buffered 8N1/8N2 UART transmitter; parity frame via UART_TX_PARITY_EN
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    input  logic [7:0]                    tx_data,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [2:0]    DATA_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CPB < 2) begin : g_bad_baud
            $error("uart_tx_ctrl: CLK_HZ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two >= 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
        end
        if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
            $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    tx_state_t   state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    logic        push;
    logic        pop;
    logic        baud_wrap;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;

    assign tx_ready  = ~fifo_full;
    assign push      = tx_valid & tx_ready;
    assign baud_wrap = (baud_cnt == BAUD_LAST);
    // The last stop cycle may reload directly so consecutive frames abut.
    assign pop       = ~fifo_empty &
                       ((state == IDLE) ||
                        ((state == STOP) && baud_wrap && (bit_idx == STOP_LAST)));
    assign tx_busy   = (state != IDLE) | ~fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            state    <= START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= fifo_rdata;
            uart_tx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        uart_tx  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            uart_tx <= parity_bit;
`else
                            state   <= STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        uart_tx  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized bench for uart_tx_ctrl against a frame-schedule model
module tb_uart_tx_ctrl;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int STOPB = 1;
    localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 1 + 8 + STOPB + PBITS;
    localparam int FLEN  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_cnt;

    uart_tx_ctrl #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (STOPB),
        .PARITY_ODD (PODD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model: each accepted byte gets an accept edge and a frame start edge.
    int         acc_q[$];
    int         st_q[$];
    logic [7:0] byte_q[$];
    int         prev_end = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        acc_q.delete();
        st_q.delete();
        byte_q.delete();
        prev_end = 0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if ((PBITS == 1) && (idx == 9)) return (^b) ^ 1'(PODD);
        return 1'b1;
    endfunction

    function automatic logic exp_line(input int t);
        foreach (st_q[i]) begin
            if ((st_q[i] <= t) && (t < st_q[i] + FLEN)) return frame_bit(byte_q[i], (t - st_q[i]) / CPB);
        end
        return 1'b1;
    endfunction

    function automatic int exp_cnt(input int t);
        int n = 0;
        foreach (acc_q[i]) begin
            if ((acc_q[i] <= t) && (st_q[i] > t)) n++;
        end
        return n;
    endfunction

    function automatic logic exp_busy(input int t);
        foreach (st_q[i]) begin
            if ((st_q[i] <= t) && (t < st_q[i] + FLEN)) return 1'b1;
        end
        return exp_cnt(t) != 0;
    endfunction

    task automatic check_outputs();
        check("uart_tx", 32'(uart_tx), 32'(exp_line(cyc)));
        check("tx_ready", 32'(tx_ready), 32'(exp_cnt(cyc) != DEPTH));
        check("tx_busy", 32'(tx_busy), 32'(exp_busy(cyc)));
        check("fifo_cnt", 32'(fifo_cnt), 32'(exp_cnt(cyc)));
    endtask

    // Called at a falling edge; drives the next rising edge and checks its result.
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        int s;
        tx_valid = v;
        tx_data  = d;
        acc = v && rst_n && (exp_cnt(cyc) != DEPTH);
        if (acc) begin
            s = (cyc + 2 > prev_end) ? cyc + 2 : prev_end;
            acc_q.push_back(cyc + 1);
            st_q.push_back(s);
            byte_q.push_back(d);
            prev_end = s + FLEN;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), a);
    endtask

    task automatic send(input logic [7:0] b);
        logic a = 1'b0;
        int guard = 0;
        while (!a && guard < 400) begin
            step(1'b1, b, a);
            guard++;
        end
        if (!a) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int guard = 0;
        while ((cyc < prev_end + 4) && guard < 2000) begin
            idle(1);
            guard++;
        end
    endtask

    initial begin
        logic a;
        int prob;
        int target;

        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        model_reset();

        idle(100);

        send(8'hA5);
        drain();

        for (int b = 1; b <= 5; b++) send(8'(b));
        drain();

        send(8'h11);
        send(8'h22);
        check("pushpop_cnt", 32'(fifo_cnt), 32'd1);
        drain();

        send(8'h07);
        drain();

        send(8'hFF);
        send(8'h3C);
        send(8'hC3);
        target = st_q[st_q.size()-3] + CPB * 4 + CPB / 2;
        while (cyc < target) idle(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_outputs();
        check("rst_line", 32'(uart_tx), 32'd1);
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(60);

        for (int i = 0; i < 2600; i++) begin
            if ((i % 200) == 0) begin
                case ($urandom_range(0, 2))
                    0: prob = 10;
                    1: prob = 50;
                    default: prob = 95;
                endcase
            end
            step($urandom_range(0, 99) < prob, 8'($urandom), a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
